// File: rtl/ram_bus_master.sv
// Burst initiator for the 32x32 single-port RAM on a shared tri-state bus.
// Sequences wrapping addresses, streams write beats in and read beats out.
module ram_bus_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              mem_ena,
    output logic              mem_wena,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam logic [LEN_W-1:0] MAXLEN = LEN_W'(2 ** ADDR_W);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   len_eff;
    logic               beat;
    logic               last;

    always_comb begin
        len_eff = cmd_len;
        if (cmd_len == '0)
            len_eff = LEN_W'(1);
        else if (cmd_len > MAXLEN)
            len_eff = MAXLEN;
    end

    assign beat = (state_q == WRITE && wr_valid) || state_q == READ;
    assign last = remaining == LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (cmd_valid) state_d = cmd_we ? WRITE : READ;
            WRITE: if (wr_valid && last) state_d = DONE;
            READ:  if (last) state_d = DONE;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= state_q == READ;
            if (state_q == READ)
                rd_data <= mem_data;
            if (state_q == IDLE && cmd_valid) begin
                cur_addr  <= cmd_addr;
                remaining <= len_eff;
            end else if (beat) begin
                cur_addr  <= cur_addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

    // Enables are masked by rst so an aborted beat never commits.
    always_comb begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_ena   = 1'b0;
        mem_wena  = 1'b0;
        mem_addr  = '0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (1'b1)
            state_q == IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            state_q == WRITE: begin
                wr_ready = 1'b1;
                mem_wena = !rst;
                mem_ena  = wr_valid && !rst;
                mem_addr = cur_addr;
            end
            state_q == READ: begin
                mem_ena  = !rst;
                mem_addr = cur_addr;
            end
            state_q == DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign mem_data = (mem_ena && mem_wena) ? wr_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Bench for ram_bus_master: RAM model on the shared bus, table vectors,
// hand sequences for stall/reset corners, then random bursts vs an array model.
module tb_ram_bus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        mem_ena;
    logic        mem_wena;
    logic [4:0]  mem_addr;
    wire  [31:0] mem_data;

    logic [31:0] ram   [32] = '{default: 32'h0};
    logic [31:0] model [32] = '{default: 32'h0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_bus_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done),
        .mem_ena(mem_ena), .mem_wena(mem_wena),
        .mem_addr(mem_addr), .mem_data(mem_data)
    );

    assign mem_data = (mem_ena && !mem_wena) ? ram[mem_addr] : 32'hzzzzzzzz;

    always @(posedge clk)
        if (mem_ena && mem_wena)
            ram[mem_addr] <= mem_data;

    typedef struct {
        bit          we;
        int          addr;
        int          len;
        logic [31:0] base;
        logic [63:0] pat;
        bit          poke;
        int          exp_beats;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic int eff_len(input int l);
        return (l == 0) ? 1 : ((l > 32) ? 32 : l);
    endfunction

    task automatic issue(input bit we, input int addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = 5'(addr);
        cmd_len   = 6'(len);
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input int addr, input int len,
                               input logic [31:0] base,
                               input logic [63:0] pat, input bit poke);
        int n = 0;
        int a = addr;
        int cyc = 0;
        int eff = eff_len(len);
        bit v;
        issue(1'b1, addr, len);
        while (n < eff && cyc < 200) begin
            v = (cyc < 64) ? pat[cyc] : 1'b1;
            wr_valid = v;
            wr_data  = base + 32'(n);
            if (poke && cyc == 0) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b0;
            end
            #1;
            chk("wr_ready", wr_ready, 1);
            chk("wr_wena", mem_wena, 1);
            chk("wr_ena", mem_ena, v);
            chk("wr_addr", mem_addr, 32'(a));
            chk("wr_busy", busy, 1);
            if (poke && cyc == 0) chk("cmd_ready_busy", cmd_ready, 0);
            if (v) begin
                chk("wr_bus", mem_data, wr_data);
                model[a] = wr_data;
                n++;
                a = (a + 1) % 32;
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
        end
        if (cyc >= 200) chk("wr_timeout", 32'(n), 32'(eff));
        wr_valid = 1'b0;
        #1;
        chk("wr_done", done, 1);
        chk("wr_done_busy", busy, 1);
        chk("wr_done_ena", mem_ena, 0);
        chk("wr_done_wrdy", wr_ready, 0);
        @(negedge clk);
        #1;
        chk("wr_done_pulse", done, 0);
        chk("wr_idle_busy", busy, 0);
    endtask

    task automatic read_burst(input int addr, input int len, input int exp_beats);
        int beats = 0;
        int a = addr;
        int cyc = 0;
        bit fin = 0;
        issue(1'b0, addr, len);
        while (!fin && cyc < 60) begin
            #1;
            if (rd_valid) begin
                chk("rd_data", rd_data, model[(addr + beats) % 32]);
                beats++;
            end
            if (done) begin
                fin = 1;
                chk("rd_last_with_done", rd_valid, 1);
                chk("rd_beats", 32'(beats), 32'(exp_beats));
            end else begin
                chk("rd_ena", mem_ena, 1);
                chk("rd_wena", mem_wena, 0);
                chk("rd_addr", mem_addr, 32'(a));
                a = (a + 1) % 32;
                @(negedge clk);
                cyc++;
            end
        end
        if (!fin) chk("rd_timeout", 32'(beats), 32'(exp_beats));
        @(negedge clk);
        #1;
        chk("rd_valid_after", rd_valid, 0);
        chk("rd_done_pulse", done, 0);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1, 5, 1, 32'hDEADBEEF, '1, 0, 1};
        vecs[1]  = '{1, 0, 4, 32'h100, '1, 0, 4};
        vecs[2]  = '{0, 0, 4, 32'h0, '1, 0, 4};
        vecs[3]  = '{1, 30, 4, 32'hA0, '1, 0, 4};
        vecs[4]  = '{0, 30, 4, 32'h0, '1, 0, 4};
        vecs[5]  = '{1, 12, 3, 32'h300, 64'h19, 0, 3};
        vecs[6]  = '{0, 12, 3, 32'h0, '1, 0, 3};
        vecs[7]  = '{1, 20, 0, 32'h400, '1, 0, 1};
        vecs[8]  = '{0, 20, 0, 32'h0, '1, 0, 1};
        vecs[9]  = '{1, 3, 40, 32'h500, '1, 1, 32};
        vecs[10] = '{0, 7, 40, 32'h0, '1, 0, 32};
        vecs[11] = '{0, 3, 32, 32'h0, '1, 0, 32};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_ena", mem_ena, 0);
        chk("rst_wena", mem_wena, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wr_ready", wr_ready, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            chk("len_clamp", 32'(eff_len(vecs[i].len)), 32'(vecs[i].exp_beats));
            if (vecs[i].we)
                write_burst(vecs[i].addr, vecs[i].len, vecs[i].base,
                            vecs[i].pat, vecs[i].poke);
            else
                read_burst(vecs[i].addr, vecs[i].len, vecs[i].exp_beats);
        end

        // reset two beats into a five-beat write
        issue(1'b1, 8, 5);
        for (int k = 0; k < 2; k++) begin
            wr_valid = 1'b1;
            wr_data  = 32'hE0 + 32'(k);
            model[8 + k] = wr_data;
            @(negedge clk);
        end
        rst      = 1'b1;
        wr_data  = 32'hBAD0;
        #1 chk("rst_mid_ena", mem_ena, 0);
        @(negedge clk);
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_wena", mem_wena, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        rst      = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        #1 chk("rst_mid_no_done", done, 0);
        read_burst(8, 5, 5);

        for (int r = 0; r < 30; r++) begin
            int ra = int'($urandom_range(0, 31));
            int rl = int'($urandom_range(0, 40));
            if ($urandom_range(0, 1) == 1)
                write_burst(ra, rl, $urandom, {$urandom, $urandom},
                            1'($urandom_range(0, 1)));
            else
                read_burst(ra, rl, eff_len(rl));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
